// File: rtl/rob_commit_if.sv
// rob_commit_if: bundles the ROB head, register-file retire, store and redirect signals of the commit stage
interface rob_commit_if #(
   parameter int w = 16,
   parameter int n = 3
);
   logic         rob_empty;
   logic         rob_valid;
   logic [1:0]   rob_op;
   logic [3:0]   rob_dest;
   logic [w-1:0] rob_value;
   logic [w-1:0] rob_addr;
   logic         rob_mispredict;
   logic [n-1:0] rob_head;
   logic         rob_re;
   logic         rf_we;
   logic [3:0]   rf_dest;
   logic [w-1:0] rf_value;
   logic [n-1:0] rf_tag;
   logic         mem_req;
   logic [w-1:0] mem_addr;
   logic [w-1:0] mem_wdata;
   logic         mem_ack;
   logic         flush;
   logic [w-1:0] redirect_pc;
   logic         halted;
   logic [15:0]  commit_count;
   logic [15:0]  flush_count;
   modport master (
      input  rob_empty, rob_valid, rob_op, rob_dest, rob_value, rob_addr, rob_mispredict, rob_head, mem_ack,
      output rob_re, rf_we, rf_dest, rf_value, rf_tag, mem_req, mem_addr, mem_wdata,
             flush, redirect_pc, halted, commit_count, flush_count
   );
   modport slave (
      output rob_empty, rob_valid, rob_op, rob_dest, rob_value, rob_addr, rob_mispredict, rob_head, mem_ack,
      input  rob_re, rf_we, rf_dest, rf_value, rf_tag, mem_req, mem_addr, mem_wdata,
             flush, redirect_pc, halted, commit_count, flush_count
   );
endinterface

// File: rtl/rob_commit_unit.sv
// rob_commit_unit: in-order ROB head retirement (ALU writeback, store handshake, mispredict flush, halt); optional statistics under COMMIT_STATS_EN
module rob_commit_unit #(
   parameter int w = 16,
   parameter int n = 3
) (
   input logic         clk,
   input logic         rst,
   rob_commit_if.master bus
);
   typedef enum logic [1:0] {RUN, STORE_WAIT, FLUSH, HALTED} state_t;
   localparam logic [1:0] op_alu    = 2'b00;
   localparam logic [1:0] op_store  = 2'b01;
   localparam logic [1:0] op_branch = 2'b10;
   localparam logic [1:0] op_halt   = 2'b11;
   state_t       state, state_nx;
   logic         ready;
   logic         gap;
   logic [n-1:0] head_tag;
   logic [w-1:0] addr_q, wdata_q, pc_q;
   assign head_tag        = bus.rob_head;
   assign bus.rf_tag      = head_tag;
   assign bus.rf_dest     = bus.rob_dest;
   assign bus.rf_value    = bus.rob_value;
   assign bus.mem_req     = state == STORE_WAIT;
   assign bus.flush       = state == FLUSH;
   assign bus.halted      = state == HALTED;
   assign bus.mem_addr    = addr_q;
   assign bus.mem_wdata   = wdata_q;
   assign bus.redirect_pc = pc_q;
   // retire decision and next state; gap blocks a pop right after a store completes
   always_comb begin
      ready      = (state == RUN) & ~rst & ~gap & ~bus.rob_empty & bus.rob_valid;
      state_nx   = state;
      bus.rob_re = 1'b0;
      bus.rf_we  = 1'b0;
      case (state)
         RUN: if (ready) begin
            bus.rob_re = bus.rob_op != op_store;
            bus.rf_we  = bus.rob_op == op_alu;
            state_nx   = bus.rob_op == op_store ? STORE_WAIT :
                         bus.rob_op == op_halt ? HALTED :
                         (bus.rob_op == op_branch && bus.rob_mispredict) ? FLUSH : RUN;
         end
         STORE_WAIT: if (bus.mem_ack && !rst) begin
            bus.rob_re = 1'b1;
            state_nx   = RUN;
         end
         FLUSH:   state_nx = RUN;
         default: state_nx = HALTED;
      endcase
   end
   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         gap   <= 1'b0;
      end else begin
         state <= state_nx;
         gap   <= (state == STORE_WAIT) & bus.mem_ack;
      end
   end
   // store address/data and redirect target captured from the head when it is accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         pc_q    <= '0;
      end else begin
         if (ready && bus.rob_op == op_store) begin
            addr_q  <= bus.rob_addr;
            wdata_q <= bus.rob_value;
         end
         if (ready && bus.rob_op == op_branch && bus.rob_mispredict) pc_q <= bus.rob_addr;
      end
   end
`ifdef COMMIT_STATS_EN
   logic [15:0] commit_q, flush_q;
   assign bus.commit_count = commit_q;
   assign bus.flush_count  = flush_q;
   // wrapping retire and flush counters
   always_ff @(posedge clk) begin
      if (rst) begin
         commit_q <= '0;
         flush_q  <= '0;
      end else begin
         commit_q <= commit_q + {15'd0, bus.rob_re};
         flush_q  <= flush_q + {15'd0, bus.flush};
      end
   end
`else
   assign bus.commit_count = '0;
   assign bus.flush_count  = '0;
`endif
endmodule

// File: tb/tb_rob_commit_unit.sv
// tb_rob_commit_unit: directed checks of retire, store, flush, halt and reset behaviour
module tb_rob_commit_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   exp_c = 0;
   int   exp_f = 0;
   rob_commit_if #(.w(16), .n(3)) bus ();
   rob_commit_unit #(.w(16), .n(3)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic idle();
      bus.rob_empty = 1'b1;
      bus.rob_valid = 1'b0;
      bus.rob_op = 2'b00;
      bus.rob_dest = 4'd0;
      bus.rob_value = 16'h0;
      bus.rob_addr = 16'h0;
      bus.rob_mispredict = 1'b0;
      bus.rob_head = 3'd0;
      bus.mem_ack = 1'b0;
   endtask
   task automatic head(input logic [1:0] op, input logic [3:0] dest, input logic [15:0] value,
                       input logic [15:0] addr, input logic misp, input logic [2:0] hd);
      bus.rob_empty = 1'b0;
      bus.rob_valid = 1'b1;
      bus.rob_op = op;
      bus.rob_dest = dest;
      bus.rob_value = value;
      bus.rob_addr = addr;
      bus.rob_mispredict = misp;
      bus.rob_head = hd;
   endtask
   task automatic test_reset();
      @(negedge clk);
      #1;
      checks++; if (bus.rob_re !== 1'b0) begin errors++; $display("FAIL reset_rob_re got %b exp 0", bus.rob_re); end
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %b exp 0", bus.rf_we); end
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", bus.mem_req); end
      checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", bus.flush); end
      checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", bus.halted); end
      checks++; if (bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_mem got %h/%h exp 0000/0000", bus.mem_addr, bus.mem_wdata); end
      checks++; if (bus.redirect_pc !== 16'h0) begin errors++; $display("FAIL reset_pc got %h exp 0000", bus.redirect_pc); end
      checks++; if (bus.commit_count !== 16'h0 || bus.flush_count !== 16'h0) begin errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", bus.commit_count, bus.flush_count); end
   endtask
   task automatic test_alu();
      @(negedge clk);
      head(2'b00, 4'd5, 16'h1234, 16'h0, 1'b0, 3'd2);
      #1;
      checks++; if (bus.rob_re !== 1'b1) begin errors++; $display("FAIL alu_rob_re got %b exp 1", bus.rob_re); end
      checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("FAIL alu_rf_we got %b exp 1", bus.rf_we); end
      checks++; if (bus.rf_dest !== 4'd5) begin errors++; $display("FAIL alu_rf_dest got %0d exp 5", bus.rf_dest); end
      checks++; if (bus.rf_value !== 16'h1234) begin errors++; $display("FAIL alu_rf_value got %h exp 1234", bus.rf_value); end
      checks++; if (bus.rf_tag !== 3'd2) begin errors++; $display("FAIL alu_rf_tag got %0d exp 2", bus.rf_tag); end
      exp_c++;
      @(negedge clk);
      head(2'b00, 4'd9, 16'hA5A5, 16'h0, 1'b0, 3'd3);
      #1;
      checks++; if (bus.rob_re !== 1'b1 || bus.rf_we !== 1'b1 || bus.rf_tag !== 3'd3) begin errors++; $display("FAIL alu_b2b got re=%b we=%b tag=%0d exp 1 1 3", bus.rob_re, bus.rf_we, bus.rf_tag); end
      exp_c++;
      @(negedge clk);
      idle();
      #1;
      checks++; if (bus.rob_re !== 1'b0 || bus.rf_we !== 1'b0) begin errors++; $display("FAIL alu_idle got re=%b we=%b exp 0 0", bus.rob_re, bus.rf_we); end
   endtask
   task automatic test_store();
      @(negedge clk);
      head(2'b01, 4'd0, 16'hBEEF, 16'h0040, 1'b0, 3'd4);
      #1;
      checks++; if (bus.rob_re !== 1'b0 || bus.mem_req !== 1'b0 || bus.rf_we !== 1'b0) begin errors++; $display("FAIL store_accept got re=%b req=%b we=%b exp 0 0 0", bus.rob_re, bus.mem_req, bus.rf_we); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.mem_ack = (i == 2);
         #1;
         checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL store_req%0d got %b exp 1", i, bus.mem_req); end
         checks++; if (bus.mem_addr !== 16'h0040 || bus.mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL store_bus%0d got %h/%h exp 0040/beef", i, bus.mem_addr, bus.mem_wdata); end
         checks++; if (bus.rob_re !== (i == 2)) begin errors++; $display("FAIL store_re%0d got %b exp %b", i, bus.rob_re, i == 2); end
      end
      exp_c++;
      @(negedge clk);
      idle();
      #1;
      checks++; if (bus.mem_req !== 1'b0 || bus.rob_re !== 1'b0) begin errors++; $display("FAIL store_done got req=%b re=%b exp 0 0", bus.mem_req, bus.rob_re); end
   endtask
   task automatic test_branch_ok();
      @(negedge clk);
      head(2'b10, 4'd0, 16'h0, 16'h0200, 1'b0, 3'd5);
      #1;
      checks++; if (bus.rob_re !== 1'b1 || bus.rf_we !== 1'b0) begin errors++; $display("FAIL branch_ok got re=%b we=%b exp 1 0", bus.rob_re, bus.rf_we); end
      exp_c++;
      @(negedge clk);
      idle();
      #1;
      checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL branch_ok_flush got %b exp 0", bus.flush); end
   endtask
   task automatic test_mispredict();
      @(negedge clk);
      head(2'b10, 4'd0, 16'h0, 16'h0100, 1'b1, 3'd6);
      #1;
      checks++; if (bus.rob_re !== 1'b1 || bus.flush !== 1'b0) begin errors++; $display("FAIL misp_pop got re=%b flush=%b exp 1 0", bus.rob_re, bus.flush); end
      exp_c++;
      @(negedge clk);
      head(2'b00, 4'd7, 16'h7777, 16'h0, 1'b0, 3'd7);
      #1;
      checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL misp_flush got %b exp 1", bus.flush); end
      checks++; if (bus.redirect_pc !== 16'h0100) begin errors++; $display("FAIL misp_pc got %h exp 0100", bus.redirect_pc); end
      checks++; if (bus.rob_re !== 1'b0 || bus.rf_we !== 1'b0) begin errors++; $display("FAIL misp_nopop got re=%b we=%b exp 0 0", bus.rob_re, bus.rf_we); end
      exp_f++;
      @(negedge clk);
      idle();
      #1;
      checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL misp_flush_end got %b exp 0", bus.flush); end
      checks++; if (bus.redirect_pc !== 16'h0100) begin errors++; $display("FAIL misp_pc_hold got %h exp 0100", bus.redirect_pc); end
   endtask
   task automatic test_empty();
      int ec, ef;
`ifdef COMMIT_STATS_EN
      ec = exp_c;
      ef = exp_f;
`else
      ec = 0;
      ef = 0;
`endif
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         head(2'b00, 4'd1, 16'h1111, 16'h0, 1'b0, 3'd1);
         bus.rob_empty = 1'b1;
         #1;
         checks++; if (bus.rob_re !== 1'b0 || bus.rf_we !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL empty%0d got re=%b we=%b req=%b exp 0 0 0", i, bus.rob_re, bus.rf_we, bus.mem_req); end
      end
      checks++; if (bus.commit_count !== 16'(ec)) begin errors++; $display("FAIL commit_count got %0d exp %0d", bus.commit_count, ec); end
      checks++; if (bus.flush_count !== 16'(ef)) begin errors++; $display("FAIL flush_count got %0d exp %0d", bus.flush_count, ef); end
      @(negedge clk);
      idle();
   endtask
   task automatic test_halt();
      @(negedge clk);
      head(2'b11, 4'd0, 16'h0, 16'h0, 1'b0, 3'd0);
      #1;
      checks++; if (bus.rob_re !== 1'b1 || bus.halted !== 1'b0) begin errors++; $display("FAIL halt_pop got re=%b halted=%b exp 1 0", bus.rob_re, bus.halted); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         head(2'b00, 4'd3, 16'h3333, 16'h0, 1'b0, 3'd1);
         #1;
         checks++; if (bus.halted !== 1'b1 || bus.rob_re !== 1'b0 || bus.rf_we !== 1'b0) begin errors++; $display("FAIL halted%0d got h=%b re=%b we=%b exp 1 0 0", i, bus.halted, bus.rob_re, bus.rf_we); end
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_reset got %b exp 0", bus.halted); end
      checks++; if (bus.rob_re !== 1'b1 || bus.rf_we !== 1'b1) begin errors++; $display("FAIL halt_rerun got re=%b we=%b exp 1 1", bus.rob_re, bus.rf_we); end
      @(negedge clk);
      idle();
   endtask
   task automatic test_reset_store();
      @(negedge clk);
      head(2'b01, 4'd0, 16'hCAFE, 16'h0080, 1'b0, 3'd2);
      @(negedge clk);
      #1;
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0080) begin errors++; $display("FAIL rst_store_pre got req=%b addr=%h exp 1 0080", bus.mem_req, bus.mem_addr); end
      rst = 1'b1;
      idle();
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_store_req got %b exp 0", bus.mem_req); end
      checks++; if (bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0 || bus.redirect_pc !== 16'h0) begin errors++; $display("FAIL rst_store_regs got %h/%h/%h exp 0", bus.mem_addr, bus.mem_wdata, bus.redirect_pc); end
      checks++; if (bus.rob_re !== 1'b0 || bus.flush !== 1'b0 || bus.halted !== 1'b0) begin errors++; $display("FAIL rst_store_ctl got re=%b fl=%b h=%b exp 0 0 0", bus.rob_re, bus.flush, bus.halted); end
      checks++; if (bus.commit_count !== 16'h0 || bus.flush_count !== 16'h0) begin errors++; $display("FAIL rst_store_counts got %0d/%0d exp 0/0", bus.commit_count, bus.flush_count); end
   endtask
   initial begin
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      test_reset();
      rst = 1'b0;
      test_alu();
      test_store();
      test_branch_ok();
      test_mispredict();
      test_empty();
      test_halt();
      test_reset_store();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
